// File: rtl/switch_box_config_loader.sv
// Config loader for the CLB switch box: shifts CW-bit chunks into a shadow
// register and commits a complete frame to the select bus c in one cycle.
module switch_box_config_loader #(
  parameter int unsigned WS         = 8,
  parameter int unsigned WD         = 8,
  parameter int unsigned CONF_WIDTH = (WS + WD / 2) * 8,
  parameter int unsigned CW         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  cfg_in_valid,
  input  logic [CW-1:0]         cfg_in_data,
  output logic                  cfg_in_ready,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [CONF_WIDTH-1:0] c
);

  localparam int unsigned N     = CONF_WIDTH / CW;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CONF_WIDTH-1:0]   shadow_q, shadow_d;
  logic [CONF_WIDTH-1:0]   c_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_d;
  logic                    accept;

  // Abort masks ready so no chunk can slip in on the abort cycle.
  assign cfg_in_ready = (state_q == LOAD) && !cfg_abort;
  assign cfg_busy     = (state_q != IDLE);
  assign accept       = cfg_in_valid && cfg_in_ready;

  // State and datapath registers; reset returns routing to all-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      c        <= '0;
      cfg_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      c        <= c_d;
      cfg_done <= done_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    c_d      = c;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          shadow_d = {cfg_in_data, shadow_q[CONF_WIDTH-1:CW]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        c_d     = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
